// File: rtl/marquee_decoder_if.sv
// Bundle of frame inputs and decoded-date outputs for the marquee decoder.
// The master drives the glyph window; the slave (decoder) returns the date.
interface marquee_decoder_if;
   logic        step;
   logic [6:0]  FirstDisplay;
   logic [6:0]  SecondDisplay;
   logic [6:0]  ThirdDisplay;
   logic [6:0]  FourthDisplay;
   logic [39:0] date_out;
   logic        date_valid;
   logic        locked;
   logic        frame_err;

   modport master (
      output step, FirstDisplay, SecondDisplay, ThirdDisplay, FourthDisplay,
      input  date_out, date_valid, locked, frame_err
   );

   modport slave (
      input  step, FirstDisplay, SecondDisplay, ThirdDisplay, FourthDisplay,
      output date_out, date_valid, locked, frame_err
   );
endinterface

// File: rtl/marquee_decoder.sv
// Follows a 4-glyph 7-segment window scrolling through "YYYY-MM-DD" and, after a
// complete consistent scroll, emits the date as a binary integer YYYYMMDD.
module marquee_decoder #(
   parameter bit ACTIVE_LOW = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   marquee_decoder_if.slave bus
);

   localparam logic [6:0] Dash = 7'h40;

   typedef enum logic [1:0] {StHunt, StTrack, StDone} state_e;

   state_e      state_q, state_d;
   logic [3:0]  k_q, k_d;
   logic [3:0]  char_q [10];
   logic [3:0]  char_d [10];
   logic [6:0]  prev_q [3];
   logic [6:0]  prev_d [3];
   logic [39:0] date_q, date_d;
   logic        valid_q, valid_d;
   logic        err_q, err_d;

   logic [6:0]  g   [4];
   logic [4:0]  dig [4];
   logic        all_digits, dash_slot, first_ok, shift_ok, hunt;
   logic [26:0] date_calc;

   // Returns {is_digit, value}.
   function automatic logic [4:0] glyph_digit(input logic [6:0] code);
      logic [4:0] r;
      case (code)
         7'h3F:   r = {1'b1, 4'd0};
         7'h06:   r = {1'b1, 4'd1};
         7'h5B:   r = {1'b1, 4'd2};
         7'h4F:   r = {1'b1, 4'd3};
         7'h66:   r = {1'b1, 4'd4};
         7'h6D:   r = {1'b1, 4'd5};
         7'h7D:   r = {1'b1, 4'd6};
         7'h07:   r = {1'b1, 4'd7};
         7'h7F:   r = {1'b1, 4'd8};
         7'h6F:   r = {1'b1, 4'd9};
         default: r = 5'd0;
      endcase
      return r;
   endfunction

   always_comb begin
      g[0] = ACTIVE_LOW ? ~bus.FirstDisplay  : bus.FirstDisplay;
      g[1] = ACTIVE_LOW ? ~bus.SecondDisplay : bus.SecondDisplay;
      g[2] = ACTIVE_LOW ? ~bus.ThirdDisplay  : bus.ThirdDisplay;
      g[3] = ACTIVE_LOW ? ~bus.FourthDisplay : bus.FourthDisplay;
      for (int i = 0; i < 4; i++) dig[i] = glyph_digit(g[i]);
   end

   always_comb begin
      all_digits = dig[0][4] & dig[1][4] & dig[2][4] & dig[3][4];
      dash_slot  = (k_q == 4'd5) || (k_q == 4'd2);
      first_ok   = dash_slot ? (g[0] == Dash) : dig[0][4];
      // Upper three glyphs must be last step's lower three, shifted left by one.
      shift_ok   = (g[1] == prev_q[0]) && (g[2] == prev_q[1]) && (g[3] == prev_q[2]);
   end

   always_comb begin
      date_calc = (27'(char_q[9]) * 27'd1000 + 27'(char_q[8]) * 27'd100
                   + 27'(char_q[7]) * 27'd10 + 27'(char_q[6])) * 27'd10000
                  + (27'(char_q[4]) * 27'd10 + 27'(char_q[3])) * 27'd100
                  + 27'(char_q[1]) * 27'd10 + 27'(char_q[0]);
   end

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      char_d  = char_q;
      prev_d  = prev_q;
      date_d  = date_q;
      valid_d = 1'b0;
      err_d   = 1'b0;
      hunt    = 1'b0;

      case (state_q)
         StHunt: hunt = bus.step;
         StTrack: begin
            if (bus.step) begin
               if (shift_ok && first_ok) begin
                  if (!dash_slot) char_d[k_q] = dig[0][3:0];
                  prev_d[0] = g[0];
                  prev_d[1] = g[1];
                  prev_d[2] = g[2];
                  if (k_q == 4'd0) state_d = StDone;
                  else             k_d     = k_q - 4'd1;
               end else begin
                  err_d   = 1'b1;
                  state_d = StHunt;
                  for (int i = 0; i < 10; i++) char_d[i] = 4'd0;
               end
            end
         end
         StDone: begin
            date_d  = {13'd0, date_calc};
            valid_d = 1'b1;
            state_d = StHunt;
            // A step landing here starts the next scroll without losing a frame.
            hunt    = bus.step;
         end
         default: state_d = StHunt;
      endcase

      if (hunt && all_digits) begin
         char_d[9] = dig[3][3:0];
         char_d[8] = dig[2][3:0];
         char_d[7] = dig[1][3:0];
         char_d[6] = dig[0][3:0];
         prev_d[0] = g[0];
         prev_d[1] = g[1];
         prev_d[2] = g[2];
         k_d       = 4'd5;
         state_d   = StTrack;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StHunt;
         k_q     <= 4'd0;
         date_q  <= 40'd0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         for (int i = 0; i < 10; i++) char_q[i] <= 4'd0;
         for (int i = 0; i < 3; i++)  prev_q[i] <= 7'd0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         date_q  <= date_d;
         valid_q <= valid_d;
         err_q   <= err_d;
         char_q  <= char_d;
         prev_q  <= prev_d;
      end
   end

   assign bus.date_out   = date_q;
   assign bus.date_valid = valid_q;
   assign bus.frame_err  = err_q;
   assign bus.locked     = (state_q != StHunt);

endmodule
